// File: rtl/mil1553_pkg.sv
// Shared MIL-STD-1553 constants and types for the encoder and decoder paths.
// Frame geometry, sync patterns, FSM states and the parity helper live here.
package mil1553_pkg;

  localparam int unsigned HB_RATE_HZ = 32'd2000000;

  localparam int unsigned SYNC_HB  = 32'd6;
  localparam int unsigned DATA_HB  = 32'd32;
  localparam int unsigned PAR_HB   = 32'd2;
  localparam int unsigned FRAME_HB = 32'd40;

  localparam logic [5:0] CMD_SYNC  = 6'b111000;
  localparam logic [5:0] DATA_SYNC = 6'b000111;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SYNC   = 2'd1,
    DATA   = 2'd2,
    PARITY = 2'd3
  } state_t;

  // Odd parity: the returned bit makes the total count of ones odd.
  function automatic logic odd_parity(input logic [15:0] data);
    return ~^data;
  endfunction

endpackage

// File: rtl/mil1553_halfbit_strobe.sv
// Half-bit timer: counts 0..DIV-1 and flags the last cycle of each half-bit.
// A synchronous clear realigns the count to the start of a new frame.
module mil1553_halfbit_strobe #(
  parameter int unsigned DIV = 32'd1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic strobe
);

  localparam int unsigned CNT_W = (DIV > 32'd1) ? $clog2(DIV) : 32'd1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 32'd1);

  logic [CNT_W-1:0] div_cnt_r;

  // Divider counter register with reset, clear and wrap at DIV-1.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_cnt_r <= {CNT_W{1'b0}};
    end else if (clr) begin
      div_cnt_r <= {CNT_W{1'b0}};
    end else if (div_cnt_r == LAST) begin
      div_cnt_r <= {CNT_W{1'b0}};
    end else begin
      div_cnt_r <= div_cnt_r + CNT_W'(1);
    end
  end

  assign strobe = (div_cnt_r == LAST);

endmodule

// File: rtl/mil1553_manchester_encoder.sv
// MIL-STD-1553 transmit encoder: serialises one 16-bit word per handshake into
// a 40 half-bit Manchester II frame (sync, 16 data bits MSB first, odd parity).
module mil1553_manchester_encoder #(
  parameter int unsigned clock_speed = 32'd2000000,
  parameter bit          invert_data = 1'b0
) (
  input  logic        aclk,
  input  logic        arstn,
  input  logic [15:0] s_axis_tdata,
  input  logic        s_axis_tuser,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  output logic        tx0_1553,
  output logic        tx1_1553,
  output logic        en_tx_1553
);

  import mil1553_pkg::*;

  localparam int unsigned DIV = clock_speed / HB_RATE_HZ;

  localparam logic [5:0] SYNC_END = 6'(SYNC_HB);
  localparam logic [5:0] DATA_END = 6'(SYNC_HB + DATA_HB);
  localparam logic [5:0] LAST_HB  = 6'(FRAME_HB - 32'd1);

  if ((clock_speed < HB_RATE_HZ) || ((clock_speed % HB_RATE_HZ) != 32'd0)) begin : g_bad_rate
    $error("clock_speed must be a non-zero integer multiple of 2000000");
  end

  state_t      state_r, state_s;
  logic [5:0]  hb_cnt_r, hb_cnt_s, nxt_hb_s;
  logic [15:0] shift_r, shift_s;
  logic [5:0]  sync_r, sync_s;
  logic        par_r, par_s;
  logic        tx0_r, tx0_s;
  logic        tx1_r, tx1_s;
  logic        en_r, en_s;
  logic        run_r;
  logic        lvl_s, upd_s, load_s;
  logic        hb_end_s, accept_s;

  mil1553_halfbit_strobe #(.DIV(DIV)) u_strobe (
    .clk    (aclk),
    .rst_n  (arstn),
    .clr    (accept_s),
    .strobe (hb_end_s)
  );

  // Ready in idle, or on the very last cycle of the parity half-bit for back-to-back words.
  assign s_axis_tready = run_r & ((state_r == IDLE) | (hb_end_s & (hb_cnt_r == LAST_HB)));
  assign accept_s      = s_axis_tvalid & s_axis_tready;
  assign nxt_hb_s      = hb_cnt_r + 6'd1;

  // Next-state, next half-bit level and frame loading.
  always_comb begin
    state_s  = state_r;
    hb_cnt_s = hb_cnt_r;
    shift_s  = shift_r;
    sync_s   = sync_r;
    par_s    = par_r;
    en_s     = en_r;
    tx0_s    = tx0_r;
    tx1_s    = tx1_r;
    lvl_s    = 1'b0;
    upd_s    = 1'b0;
    load_s   = 1'b0;

    case (state_r)
      IDLE: begin
        if (accept_s) begin
          load_s = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      SYNC, DATA, PARITY: begin
        if (!hb_end_s) begin
          state_s = state_r;
        end else if (hb_cnt_r == LAST_HB) begin
          if (accept_s) begin
            load_s = 1'b1;
          end else begin
            state_s  = IDLE;
            hb_cnt_s = 6'd0;
            en_s     = 1'b0;
            upd_s    = 1'b1;
          end
        end else begin
          hb_cnt_s = nxt_hb_s;
          upd_s    = 1'b1;
          if (nxt_hb_s < SYNC_END) begin
            state_s = SYNC;
            lvl_s   = sync_r[4];
            sync_s  = {sync_r[4:0], 1'b0};
          end else if (nxt_hb_s < DATA_END) begin
            state_s = DATA;
            // Even half-bit index carries the bit, odd carries its complement then shifts.
            if (nxt_hb_s[0] == 1'b0) begin
              lvl_s = shift_r[15];
            end else begin
              lvl_s   = ~shift_r[15];
              shift_s = {shift_r[14:0], 1'b0};
            end
          end else begin
            state_s = PARITY;
            lvl_s   = nxt_hb_s[0] ? ~par_r : par_r;
          end
        end
      end
      default: begin
        state_s = IDLE;
        en_s    = 1'b0;
        upd_s   = 1'b1;
      end
    endcase

    if (load_s) begin
      state_s  = SYNC;
      hb_cnt_s = 6'd0;
      shift_s  = s_axis_tdata;
      sync_s   = s_axis_tuser ? CMD_SYNC : DATA_SYNC;
      par_s    = odd_parity(s_axis_tdata);
      en_s     = 1'b1;
      lvl_s    = s_axis_tuser ? CMD_SYNC[5] : DATA_SYNC[5];
      upd_s    = 1'b1;
    end else begin
      shift_s = shift_s;
    end

    if (upd_s) begin
      tx0_s = en_s & (lvl_s ^ invert_data);
      tx1_s = en_s & ~(lvl_s ^ invert_data);
    end else begin
      tx0_s = tx0_r;
      tx1_s = tx1_r;
    end
  end

  // State, frame data and registered line outputs.
  always_ff @(posedge aclk) begin
    if (!arstn) begin
      state_r  <= IDLE;
      hb_cnt_r <= 6'd0;
      shift_r  <= 16'd0;
      sync_r   <= 6'd0;
      par_r    <= 1'b0;
      tx0_r    <= 1'b0;
      tx1_r    <= 1'b0;
      en_r     <= 1'b0;
      run_r    <= 1'b0;
    end else begin
      state_r  <= state_s;
      hb_cnt_r <= hb_cnt_s;
      shift_r  <= shift_s;
      sync_r   <= sync_s;
      par_r    <= par_s;
      tx0_r    <= tx0_s;
      tx1_r    <= tx1_s;
      en_r     <= en_s;
      run_r    <= 1'b1;
    end
  end

  assign tx0_1553   = tx0_r;
  assign tx1_1553   = tx1_r;
  assign en_tx_1553 = en_r;

endmodule

// File: tb/tb_mil1553_manchester_encoder.sv
// Self-checking bench: three encoder instances (DIV=1, DIV=4, inverted DIV=1)
// compared half-bit by half-bit against a frame model built from the 1553 rules.
module tb_mil1553_manchester_encoder;

  logic        aclk = 1'b0;
  logic        arstn;
  logic [15:0] tdata;
  logic        tuser;
  logic [2:0]  tvalid;
  logic [2:0]  tready, tx0, tx1, en;

  int   compared   = 0;
  int   mismatched = 0;
  int   div_of [3] = '{1, 4, 1};
  logic inv_of [3] = '{1'b0, 1'b0, 1'b1};

  always #5 aclk = ~aclk;

  mil1553_manchester_encoder #(.clock_speed(32'd2000000), .invert_data(1'b0)) u_d1 (
    .aclk(aclk), .arstn(arstn), .s_axis_tdata(tdata), .s_axis_tuser(tuser),
    .s_axis_tvalid(tvalid[0]), .s_axis_tready(tready[0]),
    .tx0_1553(tx0[0]), .tx1_1553(tx1[0]), .en_tx_1553(en[0]));

  mil1553_manchester_encoder #(.clock_speed(32'd8000000), .invert_data(1'b0)) u_d4 (
    .aclk(aclk), .arstn(arstn), .s_axis_tdata(tdata), .s_axis_tuser(tuser),
    .s_axis_tvalid(tvalid[1]), .s_axis_tready(tready[1]),
    .tx0_1553(tx0[1]), .tx1_1553(tx1[1]), .en_tx_1553(en[1]));

  mil1553_manchester_encoder #(.clock_speed(32'd2000000), .invert_data(1'b1)) u_inv (
    .aclk(aclk), .arstn(arstn), .s_axis_tdata(tdata), .s_axis_tuser(tuser),
    .s_axis_tvalid(tvalid[2]), .s_axis_tready(tready[2]),
    .tx0_1553(tx0[2]), .tx1_1553(tx1[2]), .en_tx_1553(en[2]));

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Reference frame: index 0 is the first half-bit on the (non-inverted) positive leg.
  function automatic logic [0:39] ref_frame(input logic [15:0] w, input logic cmd);
    bit q[$];
    logic [0:39] f;
    logic [5:0] sync;
    bit p;
    sync = cmd ? 6'b111000 : 6'b000111;
    for (int i = 5; i >= 0; i--) q.push_back(sync[i]);
    for (int i = 15; i >= 0; i--) begin
      q.push_back(w[i]);
      q.push_back(!w[i]);
    end
    p = (($countones(w) % 2) == 0);
    q.push_back(p);
    q.push_back(!p);
    for (int i = 0; i < 40; i++) f[i] = q[i];
    return f;
  endfunction

  task automatic send(input int d, input logic [15:0] w, input logic u);
    int guard;
    @(negedge aclk);
    tdata = w;
    tuser = u;
    tvalid[d] = 1'b1;
    guard = 0;
    while (tready[d] !== 1'b1 && guard < 200) begin
      @(negedge aclk);
      guard++;
    end
    if (guard >= 200) check("tready_timeout", {7'd0, tready[d]}, 8'd1);
  endtask

  task automatic run_frame(input int d, input logic [15:0] w, input logic u, input int ncyc,
                           input bit chain, input logic [15:0] cw, input logic cu);
    logic [0:39] f;
    logic lvl;
    int cyc;
    f = ref_frame(w, u);
    cyc = 0;
    for (int hb = 0; hb < 40; hb++) begin
      for (int c = 0; c < div_of[d]; c++) begin
        if (cyc < ncyc) begin
          @(negedge aclk);
          if (cyc == 0) begin
            if (chain) begin
              tdata = cw;
              tuser = cu;
            end else begin
              tvalid[d] = 1'b0;
              tdata = 16'($urandom);
              tuser = 1'($urandom);
            end
          end
          lvl = f[hb] ^ inv_of[d];
          check($sformatf("frame d%0d w%h hb%0d c%0d", d, w, hb, c),
                {4'd0, en[d], tx0[d], tx1[d], tready[d]},
                {4'd0, 1'b1, lvl, ~lvl, (hb == 39 && c == div_of[d] - 1)});
        end
        cyc++;
      end
    end
  endtask

  task automatic check_idle(input int d, input logic rdy);
    @(negedge aclk);
    check($sformatf("idle d%0d", d), {4'd0, en[d], tx0[d], tx1[d], tready[d]}, {7'd0, rdy});
  endtask

  initial begin
    logic [15:0] w;
    logic u;
    int d;
    arstn = 1'b0;
    tvalid = 3'b000;
    tdata = 16'h0000;
    tuser = 1'b0;

    repeat (3) @(negedge aclk);
    for (int i = 0; i < 3; i++)
      check($sformatf("reset d%0d", i), {4'd0, en[i], tx0[i], tx1[i], tready[i]}, 8'd0);
    arstn = 1'b1;
    for (int i = 0; i < 3; i++) check_idle(i, 1'b1);

    send(0, 16'h0000, 1'b1);
    run_frame(0, 16'h0000, 1'b1, 40, 1'b0, 16'h0000, 1'b0);
    check_idle(0, 1'b1);

    send(0, 16'hFFFF, 1'b0);
    run_frame(0, 16'hFFFF, 1'b0, 40, 1'b0, 16'h0000, 1'b0);
    check_idle(0, 1'b1);

    send(0, 16'hA5A5, 1'b1);
    run_frame(0, 16'hA5A5, 1'b1, 40, 1'b1, 16'h0001, 1'b0);
    run_frame(0, 16'h0001, 1'b0, 40, 1'b0, 16'h0000, 1'b0);
    check_idle(0, 1'b1);

    send(1, 16'h8000, 1'b1);
    run_frame(1, 16'h8000, 1'b1, 160, 1'b0, 16'h0000, 1'b0);
    check_idle(1, 1'b1);

    w = 16'($urandom);
    u = 1'($urandom);
    send(0, w, u);
    run_frame(0, w, u, 20, 1'b0, 16'h0000, 1'b0);
    @(negedge aclk);
    arstn = 1'b0;
    check_idle(0, 1'b0);
    arstn = 1'b1;
    check_idle(0, 1'b1);
    w = 16'($urandom);
    u = 1'($urandom);
    send(0, w, u);
    run_frame(0, w, u, 40, 1'b0, 16'h0000, 1'b0);
    check_idle(0, 1'b1);

    send(2, 16'h0000, 1'b1);
    run_frame(2, 16'h0000, 1'b1, 40, 1'b0, 16'h0000, 1'b0);
    check_idle(2, 1'b1);

    for (int k = 0; k < 6; k++) begin
      d = $urandom_range(0, 2);
      w = 16'($urandom);
      u = 1'($urandom);
      send(d, w, u);
      run_frame(d, w, u, 40 * div_of[d], 1'b0, 16'h0000, 1'b0);
      check_idle(d, 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
